// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared types and constants for the two-master memory bus
//               arbiter: FSM state encoding, master indices, the data word
//               returned on a forced (timed-out) completion, and the
//               arbitration helper used in the IDLE state.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  // Arbiter state: IDLE between transfers, GNTx while master x owns the bus.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam logic MASTER_0 = 1'b0;
  localparam logic MASTER_1 = 1'b1;

  // Read data handed back to a master whose transfer was forcibly terminated.
  localparam logic [31:0] BUS_ERR_DATA = 32'hdeadbeef;

  // Picks the next state out of IDLE. On a tie the master that was NOT
  // granted most recently wins, which yields strict alternation under load.
  function automatic arb_state_e arb_pick(input logic v0, input logic v1,
                                          input logic last_grant);
    arb_state_e nxt;
    nxt = IDLE;
    if (v0 && v1) begin
      nxt = (last_grant == MASTER_0) ? GNT1 : GNT0;
    end else if (v0) begin
      nxt = GNT0;
    end else if (v1) begin
      nxt = GNT1;
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : bus_timeout_ctr
// Description : Stall counter for a granted bus transfer. Only instantiated
//               by mem_arbiter when BUS_TIMEOUT_EN is defined.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : zero the count (held while the arbiter is idle, so every
//                  grant starts from 0)
//   en           : the transfer is waiting on the slave this cycle
//   expired      : this waiting cycle is number TIMEOUT_CYCLES of the grant;
//                  the arbiter terminates the transfer in this same cycle
// Revision    : 1.0 - initial release
// ============================================================================
module bus_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // The count holds the number of stall cycles already completed, so the
  // limit is reached during the cycle in which the count equals LIMIT-1.
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  assign expired = en && !clr && (count_q == LAST_COUNT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one picorv32-style memory bus
//               between master 0 (CPU) and master 1 (DMA). Grants are
//               registered and held until the slave completes; one idle
//               cycle separates consecutive grants.
//               Optional feature macro: BUS_TIMEOUT_EN - terminates a
//               transfer that waits TIMEOUT_CYCLES for s_ready, returning
//               BUS_ERR_DATA and latching a sticky error + address.
//   clk, reset_n        : clock, asynchronous active-low reset
//   m{0,1}_valid/instr/addr/wdata/wstrb : master requests
//   m{0,1}_ready/rdata  : per-master completion pulse and read data
//   s_valid/instr/addr/wdata/wstrb      : request towards the decoder
//   s_ready, s_rdata    : OR'd slave ready and muxed slave read data
//   bus_err, bus_err_addr : sticky timeout flag and first failing address
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        bus_err,
  output logic [31:0] bus_err_addr
);

  arb_state_e state_q;
  arb_state_e state_d;
  logic       last_grant_q;
  logic       last_grant_d;

  logic        req_valid;  // granted master's valid, before timeout masking
  logic        timeout;    // forced completion this cycle
  logic        done;       // transfer completes this cycle
  logic [31:0] rdata_sel;

  // Only the granted master feeds the bus, so the other master's inputs
  // never reach any output combinationally.
  always_comb begin
    req_valid = 1'b0;
    s_instr   = 1'b0;
    s_addr    = '0;
    s_wdata   = '0;
    s_wstrb   = '0;
    case (state_q)
      GNT0: begin
        req_valid = m0_valid;
        s_instr   = m0_instr;
        s_addr    = m0_addr;
        s_wdata   = m0_wdata;
        s_wstrb   = m0_wstrb;
      end
      GNT1: begin
        req_valid = m1_valid;
        s_instr   = m1_instr;
        s_addr    = m1_addr;
        s_wdata   = m1_wdata;
        s_wstrb   = m1_wstrb;
      end
      default: ;
    endcase
  end

  // A timeout withdraws the request from the slaves in the cycle it fires.
  // A stray s_ready while s_valid is low is masked out of done.
  assign s_valid   = req_valid & ~timeout;
  assign done      = (s_valid & s_ready) | timeout;
  assign rdata_sel = timeout ? BUS_ERR_DATA : s_rdata;

  assign m0_ready  = done & (state_q == GNT0);
  assign m1_ready  = done & (state_q == GNT1);
  assign m0_rdata  = (state_q == GNT0) ? rdata_sel : '0;
  assign m1_rdata  = (state_q == GNT1) ? rdata_sel : '0;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        state_d = arb_pick(m0_valid, m1_valid, last_grant_q);
        if (state_d == GNT0) begin
          last_grant_d = MASTER_0;
        end else if (state_d == GNT1) begin
          last_grant_d = MASTER_1;
        end
      end
      // Leave on completion, or when the owner abandons its request.
      GNT0, GNT1: begin
        if (done || !req_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // last_grant resets to master 1 so master 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= MASTER_1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  logic        bus_err_q;
  logic        bus_err_d;
  logic [31:0] bus_err_addr_q;
  logic [31:0] bus_err_addr_d;

  // The count enable uses the unmasked request so that the expiry does not
  // feed back through s_valid. s_ready in the expiry cycle suppresses it.
  bus_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state_q == IDLE),
    .en      (req_valid & ~s_ready),
    .expired (timeout)
  );

  // Sticky until reset; only the first failing address is kept.
  always_comb begin
    bus_err_d      = bus_err_q | timeout;
    bus_err_addr_d = bus_err_addr_q;
    if (timeout && !bus_err_q) begin
      bus_err_addr_d = s_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_err_q      <= 1'b0;
      bus_err_addr_q <= '0;
    end else begin
      bus_err_q      <= bus_err_d;
      bus_err_addr_q <= bus_err_addr_d;
    end
  end

  assign bus_err      = bus_err_q;
  assign bus_err_addr = bus_err_addr_q;
`else
  // Without the timeout a granted transfer waits for the slave forever.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout      = 1'b0;
  assign bus_err      = 1'b0;
  assign bus_err_addr = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. Random master traffic
//               is checked against a transaction-level model of the
//               arbitration rules (alternate on contention, otherwise the
//               sole requester) plus directed timing, reset and (with
//               BUS_TIMEOUT_EN) timeout scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_instr, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        bus_err;
  logic [31:0] bus_err_addr;

  mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .bus_err(bus_err), .bus_err_addr(bus_err_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } wr_t;

  req_t drv_q0[$], drv_q1[$], exp_q0[$], exp_q1[$];
  wr_t  wr_log[$];

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  logic model_last;         // master the model believes was granted last
  bit   slave_auto;         // 1: latency-driven slave, 0: man_ready/man_rdata
  int   slave_lat;          // ready this many cycles after s_valid; 0 = never
  int   sv_cnt;
  logic        man_ready;
  logic [31:0] man_rdata;

  function automatic logic [31:0] rd_func(input logic [31:0] a);
    return (a == 32'h100) ? 32'h12345678 : {a[15:0] ^ 16'h5a5a, ~a[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Slave model: evaluates s_valid each cycle at posedge+2.
  initial begin
    s_ready = 1'b0;
    s_rdata = 32'h0;
    sv_cnt  = 0;
    forever begin
      @(posedge clk);
      #2;
      if (slave_auto) begin
        s_ready = 1'b0;
        s_rdata = 32'h0;
        if (s_valid) sv_cnt++;
        else sv_cnt = 0;
        if (s_valid && slave_lat > 0 && sv_cnt == slave_lat + 1) begin
          s_ready = 1'b1;
          s_rdata = rd_func(s_addr);
          if (s_wstrb != 4'h0) wr_log.push_back('{s_addr, s_wdata, s_wstrb});
        end
      end else begin
        sv_cnt  = 0;
        s_ready = man_ready;
        s_rdata = man_rdata;
      end
    end
  end

  task automatic set_master(input int m, input logic v, input req_t r);
    if (m == 0) begin
      m0_valid = v; m0_instr = r.instr; m0_addr = r.addr; m0_wdata = r.wdata; m0_wstrb = r.wstrb;
    end else begin
      m1_valid = v; m1_instr = r.instr; m1_addr = r.addr; m1_wdata = r.wdata; m1_wstrb = r.wstrb;
    end
  endtask

  // Presents each queued request and holds it until that master's ready.
  task automatic drive_master(input int m);
    req_t r;
    bit   got;
    int   n;
    n = (m == 0) ? drv_q0.size() : drv_q1.size();
    for (int i = 0; i < n; i++) begin
      if (m == 0) r = drv_q0.pop_front();
      else r = drv_q1.pop_front();
      set_master(m, 1'b1, r);
      got = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
        @(negedge clk);
        got = (m == 0) ? m0_ready : m1_ready;
      end
      @(posedge clk);
      #1;
      set_master(m, 1'b0, '0);
    end
  endtask

  // Checks each completion against the arbitration rule and the slave model.
  task automatic monitor(input int total);
    int          seen;
    int          budget;
    logic        exp_m, obs_m;
    logic [31:0] rd;
    req_t        r;
    wr_t         w;
    seen   = 0;
    budget = 0;
    while (seen < total && budget < 50 * total + 50) begin
      @(negedge clk);
      budget++;
      if (m0_ready || m1_ready) begin
        chk1("single_ready", m0_ready & m1_ready, 1'b0);
        if (exp_q0.size() > 0 && exp_q1.size() > 0) exp_m = ~model_last;
        else exp_m = (exp_q0.size() > 0) ? 1'b0 : 1'b1;
        obs_m = m1_ready;
        chk1("grant_order", obs_m, exp_m);
        chk1("pending_txn", (obs_m ? exp_q1.size() : exp_q0.size()) > 0, 1'b1);
        if ((obs_m ? exp_q1.size() : exp_q0.size()) > 0) begin
          if (obs_m) begin r = exp_q1.pop_front(); rd = m1_rdata; end
          else begin r = exp_q0.pop_front(); rd = m0_rdata; end
          if (r.wstrb == 4'h0) begin
            chk("read_data", rd, rd_func(r.addr));
          end else begin
            chk1("write_seen", wr_log.size() > 0, 1'b1);
            if (wr_log.size() > 0) begin
              w = wr_log.pop_front();
              chk("wr_addr", w.addr, r.addr);
              chk("wr_wdata", w.wdata, r.wdata);
              chk("wr_wstrb", {28'h0, w.wstrb}, {28'h0, r.wstrb});
            end
          end
        end
        model_last = obs_m;
        seen++;
      end
    end
    chk("burst_complete", seen, total);
    exp_q0.delete();
    exp_q1.delete();
    wr_log.delete();
  endtask

  task automatic burst(input int n0, input int n1, input int wr_pct);
    req_t r;
    slave_auto = 1'b1;
    slave_lat  = $urandom_range(1, 3);
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < ((m == 0) ? n0 : n1); i++) begin
        r.instr = 1'($urandom_range(0, 1));
        r.addr  = $urandom & 32'hffff_fffc;
        r.wdata = $urandom;
        r.wstrb = ($urandom_range(0, 99) < wr_pct) ? 4'($urandom_range(1, 15)) : 4'h0;
        if (m == 0) begin drv_q0.push_back(r); exp_q0.push_back(r); end
        else begin drv_q1.push_back(r); exp_q1.push_back(r); end
      end
    end
    @(posedge clk);
    #1;
    fork
      drive_master(0);
      drive_master(1);
      monitor(n0 + n1);
    join
  endtask

`ifdef BUS_TIMEOUT_EN
  // Single read held off by the slave for the whole timeout window; with
  // give_ready the slave answers in exactly the last window cycle.
  task automatic stall_window(input int m, input logic [31:0] addr, input bit give_ready);
    logic early;
    slave_auto = 1'b0;
    man_ready  = 1'b0;
    man_rdata  = 32'h0;
    @(posedge clk);
    #1;
    set_master(m, 1'b1, '{1'b0, addr, 32'h0, 4'h0});
    early = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      @(posedge clk);
      #1;
      if (k == TMO && give_ready) begin
        man_ready = 1'b1;
        man_rdata = 32'h55aa_33cc;
      end
      @(negedge clk);
      if (k < TMO) early = early | m0_ready | m1_ready;
    end
    chk1("tmo_no_early_ready", early, 1'b0);
    chk1("tmo_ready", (m == 0) ? m0_ready : m1_ready, 1'b1);
    chk("tmo_rdata", (m == 0) ? m0_rdata : m1_rdata,
        give_ready ? 32'h55aa_33cc : 32'hdeadbeef);
    chk1("tmo_s_valid", s_valid, give_ready);
    @(posedge clk);
    #1;
    set_master(m, 1'b0, '0);
    man_ready = 1'b0;
    @(negedge clk);
    model_last = (m == 1);
  endtask
`endif

  initial begin
    req_t r;
    logic hold_ok;
    reset_n    = 1'b0;
    slave_auto = 1'b1;
    slave_lat  = 1;
    man_ready  = 1'b0;
    man_rdata  = 32'h0;
    model_last = 1'b1;
    set_master(0, 1'b0, '0);
    set_master(1, 1'b0, '0);
    #1;
    chk1("rst_s_valid", s_valid, 1'b0);
    chk1("rst_m0_ready", m0_ready, 1'b0);
    chk1("rst_m1_ready", m1_ready, 1'b0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_s_addr", s_addr, 32'h0);
    chk1("rst_bus_err", bus_err, 1'b0);
    chk("rst_bus_err_addr", bus_err_addr, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Tie straight after reset: m0 first, then m1.
    burst(1, 1, 50);

    // Single master read of 0x100 with a one-cycle slave.
    slave_lat = 1;
    @(posedge clk);
    #1;
    r = '{1'b1, 32'h100, 32'h0, 4'h0};
    set_master(0, 1'b1, r);
    @(negedge clk);
    chk1("t1_req_cycle_s_valid", s_valid, 1'b0);
    @(posedge clk); @(negedge clk);
    chk1("t1_grant_s_valid", s_valid, 1'b1);
    chk("t1_s_addr", s_addr, 32'h100);
    chk1("t1_s_instr", s_instr, 1'b1);
    chk1("t1_early_ready", m0_ready, 1'b0);
    @(posedge clk); @(negedge clk);
    chk1("t1_m0_ready", m0_ready, 1'b1);
    chk("t1_m0_rdata", m0_rdata, 32'h12345678);
    chk1("t1_m1_ready", m1_ready, 1'b0);
    @(posedge clk);
    #1;
    set_master(0, 1'b0, '0);
    @(negedge clk);
    chk1("t1_idle_after", s_valid, 1'b0);
    model_last = 1'b0;

    // Sustained contention with writes, then mixed random traffic.
    burst(4, 4, 100);
    burst(6, 6, 50);
    burst(3, 0, 50);
    burst(0, 3, 50);
    burst(5, 2, 50);

    // Reset in the middle of a GNT1 transfer.
    slave_lat = 0;
    @(posedge clk);
    #1;
    r = '{1'b0, 32'h300, 32'h0, 4'h0};
    set_master(1, 1'b1, r);
    @(negedge clk);
    chk1("rst_mid_req_idle", s_valid, 1'b0);
    @(posedge clk); @(negedge clk);
    chk1("rst_mid_granted", s_valid, 1'b1);
    chk("rst_mid_s_addr", s_addr, 32'h300);
    #2;
    reset_n = 1'b0;
    #1;
    chk1("rst_mid_s_valid", s_valid, 1'b0);
    chk1("rst_mid_m1_ready", m1_ready, 1'b0);
    chk("rst_mid_s_addr_zero", s_addr, 32'h0);
    @(posedge clk);
    #1;
    set_master(1, 1'b0, '0);
    reset_n = 1'b1;
    model_last = 1'b1;
    @(negedge clk);
    chk1("rst_mid_idle", s_valid, 1'b0);
    burst(1, 1, 0);

`ifdef BUS_TIMEOUT_EN
    stall_window(0, 32'h200, 1'b1);
    chk1("race_bus_err", bus_err, 1'b0);
    chk("race_bus_err_addr", bus_err_addr, 32'h0);
    stall_window(1, 32'h9000_0000, 1'b0);
    chk1("tmo1_bus_err", bus_err, 1'b1);
    chk("tmo1_bus_err_addr", bus_err_addr, 32'h9000_0000);
    stall_window(0, 32'ha000_0004, 1'b0);
    chk1("tmo2_bus_err", bus_err, 1'b1);
    chk("tmo2_bus_err_addr", bus_err_addr, 32'h9000_0000);
    burst(2, 2, 50);
`else
    // Stalled slave: the grant must be held indefinitely.
    slave_auto = 1'b1;
    slave_lat  = 0;
    @(posedge clk);
    #1;
    r = '{1'b0, 32'h9000_0000, 32'h0, 4'h0};
    set_master(1, 1'b1, r);
    @(negedge clk);
    hold_ok = 1'b1;
    for (int k = 0; k < 1100; k++) begin
      @(posedge clk); @(negedge clk);
      if (!(s_valid === 1'b1 && m1_ready === 1'b0 && m0_ready === 1'b0 && bus_err === 1'b0))
        hold_ok = 1'b0;
    end
    chk1("stall_hold_1100", hold_ok, 1'b1);
    chk1("stall_bus_err", bus_err, 1'b0);
    chk("stall_bus_err_addr", bus_err_addr, 32'h0);
    slave_auto = 1'b0;
    @(posedge clk);
    #1;
    man_ready = 1'b1;
    man_rdata = 32'hcafe_f00d;
    @(negedge clk);
    chk1("stall_release_ready", m1_ready, 1'b1);
    chk("stall_release_rdata", m1_rdata, 32'hcafe_f00d);
    @(posedge clk);
    #1;
    man_ready = 1'b0;
    set_master(1, 1'b0, '0);
    model_last = 1'b1;
    burst(2, 2, 50);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
